// File: rtl/asteroids_pkg.sv
// Shared types and constants for the asteroids collision/scoring logic.
package asteroids_pkg;

  typedef enum logic [1:0] {PLAY, INVULN, OVER} state_t;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int SCORE_MAX_DEF = 9999;
  localparam int SCORE_W       = 14;
  localparam int MAX_LANES     = 32;

  function automatic logic [SCORE_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/collision_detector_eof_detect.sv
// One-cycle end-of-frame pulse on the first clock with py==V_ACTIVE.
// Combinational from py; holding py at V_ACTIVE for many clocks yields one pulse.
module eof_detect #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] py,
  output logic       eof
);

  localparam logic [9:0] V_END = 10'(V_ACTIVE);

  logic at_end;
  logic at_end_q;

  assign at_end = (py == V_END);
  assign eof    = at_end & ~at_end_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) at_end_q <= 1'b0;
    else         at_end_q <= at_end;
  end

endmodule

// File: rtl/collision_detector.sv
// Frame-accumulated rock/bullet/ship collisions, score, lives and play state; results update at EOF and hold one frame.
// Optional ROCK_ROCK_COLLIDE_EN also resets rocks that overlap each other (no score).
module collision_detector
  import asteroids_pkg::*;
#(
  parameter int NUM_ROCKS     = 10,
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int SCORE_MAX     = SCORE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [9:0]           px,
  input  logic [9:0]           py,
  input  logic [NUM_ROCKS-1:0] rock_pixel,
  input  logic                 bullet_pixel,
  input  logic                 ship_pixel,
  input  logic                 restart,
  output logic [NUM_ROCKS-1:0] rock_reset,
  output logic                 bullet_clear,
  output logic                 ship_hit,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives,
  output logic                 game_over
);

  localparam int              CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [9:0]      H_END = 10'(H_ACTIVE);
  localparam logic [9:0]      V_END = 10'(V_ACTIVE);
  localparam logic [SCORE_W:0] SAT  = (SCORE_W + 1)'(SCORE_MAX);

  state_t               state;
  logic [CNT_W-1:0]     invuln_cnt;
  logic [NUM_ROCKS-1:0] shot_acc;
  logic [NUM_ROCKS-1:0] ram_acc;
  logic                 crash_acc;
  logic [NUM_ROCKS-1:0] hit_vec;
  logic                 eof;
  logic                 active;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;

  eof_detect #(.V_ACTIVE(V_ACTIVE)) u_eof (
    .clk    (clk),
    .resetn (resetn),
    .py     (py),
    .eof    (eof)
  );

  assign active = (px < H_END) && (py < V_END);

  // Extra MSB catches the carry so the sum saturates instead of wrapping.
  assign score_sum  = {1'b0, score} + {1'b0, popcount(MAX_LANES'(shot_acc))};
  assign score_next = (score_sum > SAT) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];

`ifdef ROCK_ROCK_COLLIDE_EN
  logic [NUM_ROCKS-1:0] rock_acc;
  logic [NUM_ROCKS-1:0] rr_now;

  always_comb begin
    rr_now = '0;
    for (int i = 0; i < NUM_ROCKS; i++)
      rr_now[i] = rock_pixel[i] & (|(rock_pixel & ~(NUM_ROCKS'(1) << i)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rock_acc <= '0;
    else if (eof)    rock_acc <= '0;
    else if (active) rock_acc <= rock_acc | rr_now;
  end

  assign hit_vec = shot_acc | ram_acc | rock_acc;
`else
  assign hit_vec = shot_acc | ram_acc;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shot_acc  <= '0;
      ram_acc   <= '0;
      crash_acc <= 1'b0;
    end else if (eof) begin
      shot_acc  <= '0;
      ram_acc   <= '0;
      crash_acc <= 1'b0;
    end else if (active) begin
      shot_acc  <= shot_acc | (rock_pixel & {NUM_ROCKS{bullet_pixel}});
      ram_acc   <= ram_acc  | (rock_pixel & {NUM_ROCKS{ship_pixel}});
      crash_acc <= crash_acc | (ship_pixel & (|rock_pixel));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= PLAY;
      invuln_cnt   <= '0;
      rock_reset   <= '0;
      bullet_clear <= 1'b0;
      ship_hit     <= 1'b0;
      score        <= '0;
      lives        <= 3'(START_LIVES);
      game_over    <= 1'b0;
    end else if (eof) begin
      rock_reset   <= hit_vec;
      bullet_clear <= |shot_acc;
      ship_hit     <= 1'b0;
      case (state)
        PLAY: begin
          score <= score_next;
          if (crash_acc) begin
            lives    <= lives - 3'd1;
            ship_hit <= 1'b1;
            if (lives == 3'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state      <= INVULN;
              invuln_cnt <= CNT_W'(INVULN_FRAMES);
            end
          end
        end
        INVULN: begin
          score <= score_next;
          if (invuln_cnt <= CNT_W'(1)) begin
            state      <= PLAY;
            invuln_cnt <= '0;
          end else begin
            invuln_cnt <= invuln_cnt - CNT_W'(1);
          end
        end
        OVER: begin
          rock_reset <= '1;
          if (restart) begin
            state        <= PLAY;
            game_over    <= 1'b0;
            lives        <= 3'(START_LIVES);
            score        <= '0;
            rock_reset   <= '0;
            bullet_clear <= 1'b0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboarded bench for collision_detector on a shrunken 4x2 visible raster (5x3 total scan).
module tb_collision_detector;

  localparam int NR = 10;
  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HT = 5;
  localparam int VT = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic [9:0]    px, py;
  logic [NR-1:0] rock_pixel;
  logic          bullet_pixel, ship_pixel, restart;
  logic [NR-1:0] rock_reset;
  logic          bullet_clear, ship_hit;
  logic [13:0]   score;
  logic [2:0]    lives;
  logic          game_over;

  typedef struct packed {
    logic [9:0]  rr;
    logic        bc;
    logic        sh;
    logic [13:0] score;
    logic [2:0]  lives;
    logic        go;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks   = 0;
  int   errors   = 0;
  int   frame_no = 0;

  always #5 clk = ~clk;

  collision_detector #(
    .NUM_ROCKS(NR), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .START_LIVES(3), .INVULN_FRAMES(120), .SCORE_MAX(9999)
  ) dut (
    .clk(clk), .resetn(resetn), .px(px), .py(py),
    .rock_pixel(rock_pixel), .bullet_pixel(bullet_pixel), .ship_pixel(ship_pixel),
    .restart(restart), .rock_reset(rock_reset), .bullet_clear(bullet_clear),
    .ship_hit(ship_hit), .score(score), .lives(lives), .game_over(game_over)
  );

  function automatic exp_t mk(input logic [9:0] rr, input logic bc, input logic sh,
                              input int sc, input int lv, input logic go);
    exp_t e;
    e.rr = rr; e.bc = bc; e.sh = sh;
    e.score = 14'(sc); e.lives = 3'(lv); e.go = go;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (frame %0d): got %0h, expected %0h", nm, frame_no, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".rock_reset"},   32'(rock_reset),   32'(e.rr));
    check({tag, ".bullet_clear"}, 32'(bullet_clear), 32'(e.bc));
    check({tag, ".ship_hit"},     32'(ship_hit),     32'(e.sh));
    check({tag, ".score"},        32'(score),        32'(e.score));
    check({tag, ".lives"},        32'(lives),        32'(e.lives));
    check({tag, ".game_over"},    32'(game_over),    32'(e.go));
  endtask

  // mode 1: hit on the first nhit visible pixels; mode 2: hit only on off-screen pixels
  task automatic frame(input logic [NR-1:0] rk, input logic bl, input logic sh,
                       input int mode, input int nhit, input logic rs,
                       input logic do_rst, input exp_t e);
    int   n;
    logic hit;
    q.push_back(e);
    n = 0;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
        if (x == 0 && y == 0) restart = rs;
        hit = 1'b0;
        if (mode == 1 && x < HA && y < VA && n < nhit) begin
          hit = 1'b1;
          n++;
        end
        if (mode == 2 && x >= HA && y < VA) hit = 1'b1;
        rock_pixel   = hit ? rk : '0;
        bullet_pixel = hit & bl;
        ship_pixel   = hit & sh;
        if (do_rst && x == 3 && y == 1) begin
          resetn = 1'b0;
          #1;
          check_out("async_reset", mk(10'h000, 0, 0, 0, 3, 0));
        end
        if (do_rst && x == 4 && y == 1) resetn = 1'b1;
      end
    end
  endtask

  // Monitor: outputs are compared right after the EOF edge and again mid-frame for hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resetn === 1'b1 && py == 10'(VA) && px == 10'd0) begin
        frame_no++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL eof_unexpected (frame %0d): got EOF with empty queue, expected none", frame_no);
        end else begin
          cur = q.pop_front();
          check_out("eof", cur);
        end
      end else if (resetn === 1'b1 && py == 10'd1 && px == 10'd2) begin
        check_out("hold", cur);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    exp_t rr_exp;
    resetn = 1'b0; px = '0; py = '0; rock_pixel = '0;
    bullet_pixel = 1'b0; ship_pixel = 1'b0; restart = 1'b0;
    cur = mk(10'h000, 0, 0, 0, 3, 0);
    repeat (3) @(negedge clk);
    #1;
    check_out("reset", mk(10'h000, 0, 0, 0, 3, 0));
    @(negedge clk);
    resetn = 1'b1;

    // single shot on rock 2, then hold and clear; restart in PLAY ignored
    frame(10'h004, 1, 0, 1, 4, 0, 0, mk(10'h004, 1, 0, 1, 3, 0));
    frame(10'h000, 0, 0, 0, 0, 1, 0, mk(10'h000, 0, 0, 1, 3, 0));
    // rocks 0,3,5 shot together
    frame(10'h029, 1, 0, 1, 2, 0, 0, mk(10'h029, 1, 0, 4, 3, 0));
    // everything overlapping, but only off-screen
    frame(10'h3FF, 1, 1, 2, 0, 0, 0, mk(10'h000, 0, 0, 4, 3, 0));
    // rock-rock overlap
`ifdef ROCK_ROCK_COLLIDE_EN
    rr_exp = mk(10'h003, 0, 0, 4, 3, 0);
`else
    rr_exp = mk(10'h000, 0, 0, 4, 3, 0);
`endif
    frame(10'h003, 0, 0, 1, 2, 0, 0, rr_exp);

    // ship rams rock 1: one life lost, then 120 immune frames that still reset the rock
    frame(10'h002, 0, 1, 1, 1, 0, 0, mk(10'h002, 0, 1, 4, 2, 0));
    for (int k = 0; k < 120; k++)
      frame(10'h002, 0, 1, 1, 1, 0, 0, mk(10'h002, 0, 0, 4, 2, 0));
    frame(10'h000, 0, 0, 0, 0, 0, 0, mk(10'h000, 0, 0, 4, 2, 0));
    // shot and crash on the same rock: scores once and costs a life
    frame(10'h002, 1, 1, 1, 1, 0, 0, mk(10'h002, 1, 1, 5, 1, 0));
    for (int k = 0; k < 119; k++)
      frame(10'h000, 0, 0, 0, 0, 0, 0, mk(10'h000, 0, 0, 5, 1, 0));
    // last immune frame ignores the crash; the next one is fatal
    frame(10'h002, 0, 1, 1, 1, 0, 0, mk(10'h002, 0, 0, 5, 1, 0));
    frame(10'h002, 0, 1, 1, 1, 0, 0, mk(10'h002, 0, 1, 5, 0, 1));
    // game over: all rocks reset, score frozen, then restart
    frame(10'h001, 1, 0, 1, 1, 0, 0, mk(10'h3FF, 1, 0, 5, 0, 1));
    frame(10'h000, 0, 0, 0, 0, 0, 0, mk(10'h3FF, 0, 0, 5, 0, 1));
    frame(10'h000, 0, 0, 0, 0, 1, 0, mk(10'h000, 0, 0, 0, 3, 0));

    // score ramp to saturation
    for (int k = 1; k <= 999; k++)
      frame(10'h3FF, 1, 0, 1, 1, 0, 0, mk(10'h3FF, 1, 0, 10 * k, 3, 0));
    frame(10'h0FF, 1, 0, 1, 1, 0, 0, mk(10'h0FF, 1, 0, 9998, 3, 0));
    frame(10'h007, 1, 0, 1, 1, 0, 0, mk(10'h007, 1, 0, 9999, 3, 0));
    frame(10'h3FF, 1, 0, 1, 1, 0, 0, mk(10'h3FF, 1, 0, 9999, 3, 0));

    // async reset mid-frame discards the pending shot
    frame(10'h004, 1, 0, 1, 1, 0, 1, mk(10'h000, 0, 0, 0, 3, 0));

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
